// File: rtl/ex_pkg.sv
// Shared types for the execute stage: opcodes, FSM states and condition-flag layout.
package ex_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_BEQ   = 4'd9,
        OP_BNE   = 4'd10,
        OP_PASSB = 4'd11,
        OP_MUL   = 4'd12
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/ex_iter_mul.sv
// Shift-add multiplier: one partial product per cycle, low DATA_W product bits.
// A finished product is held on the outputs while hold_i is asserted.
module ex_iter_mul #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort_i,
    input  logic              start_i,
    input  logic              hold_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] step_sum_s;

    // The last step's sum is the product, so it is exposed before being registered.
    assign step_sum_s = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product_o  = step_sum_s;
    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == '0);

    // Next-state: abort beats start, counting runs freely, finishing waits for hold_i.
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        busy_d   = busy_q;
        if (abort_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = CNT_W'(DATA_W - 1);
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
        end else if (busy_q && (cnt_q != '0)) begin
            acc_d    = step_sum_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
        end else if (done_o && !hold_i) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage: ALU, branch resolution, condition flags and iterative multiply,
// presented through a valid/ready result register with stall and flush.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 6,
    parameter int COND_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic              use_imm,
    input  logic              set_cond,
    input  logic [DATA_W-1:0] dataA,
    input  logic [DATA_W-1:0] dataB,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] br_imm,
    input  logic [DATA_W-1:0] pc,
    input  logic [RD_W-1:0]   rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] new_pc,
    output logic [DATA_W-1:0] imm_out,
    output logic [RD_W-1:0]   rd_out,
    output logic              branch_taken,
    output logic [COND_W-1:0] cond_out
);
    localparam int SH_W = $clog2(DATA_W);

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] npc_q, npc_d;
    logic [DATA_W-1:0] immo_q, immo_d;
    logic [RD_W-1:0]   rdo_q, rdo_d;
    logic              taken_q, taken_d;
    logic [COND_W-1:0] cond_q, cond_d;
    logic [DATA_W-1:0] m_npc_q, m_npc_d;
    logic [DATA_W-1:0] m_imm_q, m_imm_d;
    logic [RD_W-1:0]   m_rd_q, m_rd_d;
    logic              m_sc_q, m_sc_d;

    op_e               op_s;
    logic [DATA_W-1:0] opb_s, res_s, npc_s, mul_prod_s;
    logic [DATA_W:0]   sum_s, diff_s;
    logic [SH_W-1:0]   shamt_s;
    logic              c_s, v_s, taken_s;
    logic              out_free_s, accept_s, load_alu_s, start_mul_s, mul_finish_s;
    logic              mul_busy_s, mul_done_s;
    logic [COND_W-1:0] alu_flags_s, mul_flags_s;

    assign op_s         = op_e'(op);
    assign out_free_s   = !out_valid_q || out_ready;
    assign in_ready     = (state_q == IDLE) && out_free_s && !flush;
    assign accept_s     = in_valid && in_ready;
    assign start_mul_s  = accept_s && (op_s == OP_MUL);
    assign load_alu_s   = accept_s && (op_s != OP_MUL);
    assign mul_finish_s = (state_q == MUL) && mul_busy_s && mul_done_s && out_free_s;
    assign npc_s        = pc + br_imm;

    ex_iter_mul #(.DATA_W(DATA_W)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .abort_i   (flush),
        .start_i   (start_mul_s),
        .hold_i    (!out_free_s),
        .a_i       (dataA),
        .b_i       (opb_s),
        .busy_o    (mul_busy_s),
        .done_o    (mul_done_s),
        .product_o (mul_prod_s)
    );

    // Single-cycle ALU with carry/overflow taken from a one-bit-wider add/sub.
    always_comb begin
        opb_s   = use_imm ? imm : dataB;
        sum_s   = {1'b0, dataA} + {1'b0, opb_s};
        diff_s  = {1'b0, dataA} - {1'b0, opb_s};
        shamt_s = opb_s[SH_W-1:0];
        res_s   = '0;
        c_s     = 1'b0;
        v_s     = 1'b0;
        taken_s = 1'b0;
        case (op_s)
            OP_ADD: begin
                res_s = sum_s[DATA_W-1:0];
                c_s   = sum_s[DATA_W];
                v_s   = (dataA[DATA_W-1] == opb_s[DATA_W-1]) && (sum_s[DATA_W-1] != dataA[DATA_W-1]);
            end
            OP_SUB: begin
                res_s = diff_s[DATA_W-1:0];
                c_s   = !diff_s[DATA_W];
                v_s   = (dataA[DATA_W-1] != opb_s[DATA_W-1]) && (diff_s[DATA_W-1] != dataA[DATA_W-1]);
            end
            OP_AND:   res_s = dataA & opb_s;
            OP_OR:    res_s = dataA | opb_s;
            OP_XOR:   res_s = dataA ^ opb_s;
            OP_SLL:   res_s = dataA << shamt_s;
            OP_SRL:   res_s = dataA >> shamt_s;
            OP_SRA:   res_s = $signed(dataA) >>> shamt_s;
            OP_SLT:   res_s = {{(DATA_W-1){1'b0}}, ($signed(dataA) < $signed(opb_s))};
            OP_BEQ: begin
                res_s   = diff_s[DATA_W-1:0];
                c_s     = !diff_s[DATA_W];
                taken_s = (dataA == opb_s);
            end
            OP_BNE: begin
                res_s   = diff_s[DATA_W-1:0];
                c_s     = !diff_s[DATA_W];
                taken_s = (dataA != opb_s);
            end
            OP_PASSB: res_s = opb_s;
            default:  res_s = '0;
        endcase
        alu_flags_s = COND_W'(pack_flags(res_s[DATA_W-1], res_s == '0, c_s, v_s));
        mul_flags_s = COND_W'(pack_flags(mul_prod_s[DATA_W-1], mul_prod_s == '0, 1'b0, 1'b0));
    end

    // Next-state: flush beats load and completion; the output register holds under stall.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        npc_d       = npc_q;
        immo_d      = immo_q;
        rdo_d       = rdo_q;
        taken_d     = taken_q;
        cond_d      = cond_q;
        m_npc_d     = m_npc_q;
        m_imm_d     = m_imm_q;
        m_rd_d      = m_rd_q;
        m_sc_d      = m_sc_q;
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end else if (load_alu_s) begin
            out_valid_d = 1'b1;
            res_d       = res_s;
            npc_d       = npc_s;
            immo_d      = br_imm;
            rdo_d       = rd;
            taken_d     = taken_s;
            if (set_cond) cond_d = alu_flags_s;
            else          cond_d = cond_q;
        end else if (mul_finish_s) begin
            out_valid_d = 1'b1;
            state_d     = IDLE;
            res_d       = mul_prod_s;
            npc_d       = m_npc_q;
            immo_d      = m_imm_q;
            rdo_d       = m_rd_q;
            taken_d     = 1'b0;
            if (m_sc_q) cond_d = mul_flags_s;
            else        cond_d = cond_q;
        end else if (start_mul_s) begin
            state_d = MUL;
            m_npc_d = npc_s;
            m_imm_d = br_imm;
            m_rd_d  = rd;
            m_sc_d  = set_cond;
            if (out_ready) out_valid_d = 1'b0;
            else           out_valid_d = out_valid_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Stage registers; reset overrides everything including an in-flight multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            npc_q       <= '0;
            immo_q      <= '0;
            rdo_q       <= '0;
            taken_q     <= 1'b0;
            cond_q      <= '0;
            m_npc_q     <= '0;
            m_imm_q     <= '0;
            m_rd_q      <= '0;
            m_sc_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            npc_q       <= npc_d;
            immo_q      <= immo_d;
            rdo_q       <= rdo_d;
            taken_q     <= taken_d;
            cond_q      <= cond_d;
            m_npc_q     <= m_npc_d;
            m_imm_q     <= m_imm_d;
            m_rd_q      <= m_rd_d;
            m_sc_q      <= m_sc_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign alu_result   = res_q;
    assign new_pc       = npc_q;
    assign imm_out      = immo_q;
    assign rd_out       = rdo_q;
    assign branch_taken = taken_q;
    assign cond_out     = cond_q;

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
Parametrised successor of the single-cycle execute stage. It takes operands, immediates, PC and destination register from decode, computes the ALU result and the branch target, and resolves the branch. It keeps a condition-flag reserve register and presents all results through a valid/ready output register to the memory stage. It adds a multi-cycle iterative multiply, pipeline stall (backpressure) and flush, none of which the single-cycle stage has.

Parameters:
DATA_W, 32, operand/result/PC width (>=8)
RD_W, 6, destination register index width
COND_W, 4, condition flag width (N,Z,C,V; fixed layout, must be 4)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  kill in-flight and registered op this cycle
in_valid  in  1  decode presents an op
in_ready  out  1  stage accepts op this cycle
op  in  4  operation code (ex_pkg::op_e)
use_imm  in  1  operand B = imm instead of dataB
set_cond  in  1  update flag register when op completes
dataA  in  DATA_W  operand A
dataB  in  DATA_W  operand B register value
imm  in  DATA_W  sign-extended ALU/LS immediate
br_imm  in  DATA_W  branch offset
pc  in  DATA_W  PC of op
rd  in  RD_W  destination register
out_valid  out  1  result register holds a valid op
out_ready  in  1  memory stage accepts result
alu_result  out  DATA_W  ALU/multiply result
new_pc  out  DATA_W  pc + br_imm
imm_out  out  DATA_W  br_imm passthrough
rd_out  out  RD_W  destination passthrough
branch_taken  out  1  branch condition true
cond_out  out  COND_W  flag register value

Behaviour:
- Reset: state=IDLE, out_valid=0, alu_result=0, new_pc=0, imm_out=0, rd_out=0, branch_taken=0, cond_out=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept = in_valid && in_ready. Operand B = use_imm ? imm : dataB.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, BEQ, BNE, PASSB): the result register loads on the accept edge; out_valid=1 on the next cycle. Latency is 1.
- Shifts use B[log2(DATA_W)-1:0]. SLT is signed and gives 1 or 0. Arithmetic wraps modulo 2^DATA_W.
- BEQ/BNE: branch_taken = (A==B) / (A!=B), and alu_result = A-B. branch_taken is 0 for every other op.
- new_pc = pc + br_imm, modulo 2^DATA_W, for every op.
- MUL: on accept, FSM goes IDLE->MUL and latches operands, pc, rd and immediates. It runs a shift-add loop for DATA_W cycles, driven by a counter from DATA_W-1 down to 0. On the cycle the counter reaches 0 it writes the low DATA_W bits of the product and returns to IDLE; out_valid rises the next cycle. Latency is DATA_W+1 cycles. in_ready=0 while in MUL.
- Flags: computed from the final result. N=msb, Z=(result==0). C = carry-out for ADD, no-borrow for SUB/BEQ/BNE, 0 otherwise. V = signed overflow for ADD/SUB, 0 otherwise. The register updates only when the op completes with set_cond=1 and no flush. cond_out holds its value otherwise.
- Backpressure: when out_valid && !out_ready, all output registers hold. A finished MUL waits in MUL (counter=0) until the output register frees.
- flush: same edge clears out_valid and aborts MUL (state->IDLE). Flags are not updated for the killed op. flush has priority over accept and completion.
- rst has priority over flush and everything else, including mid-MUL.
- A simultaneous out_ready and accept is legal. The register is replaced with the new op and out_valid stays 1.

Decomposition:
- ex_pkg holds op_e (4-bit enum), the flag bit index constants (N=3,Z=2,C=1,V=0), and the state_e enum {IDLE, MUL}.
- One sub-module, ex_iter_mul: a DATA_W-parameterised shift-add multiplier with start/busy/done and hold-on-stall. All else stays inline.

Test Plan:
- rst held 2 cycles, then ADD A=5, B=imm=3, use_imm=1, set_cond=1 -> next cycle out_valid=1, alu_result=8, cond_out=4'b0000, new_pc=pc+br_imm.
- SUB A=3, B=3, set_cond=1; then BEQ A=7, dataB=7, pc=0x100, br_imm=0x20 -> first op gives cond_out=4'b0110; second gives branch_taken=1, new_pc=0x120.
- ADD 0x7FFFFFFF + 1, set_cond=1 -> alu_result=0x80000000, cond_out=4'b1001.
- MUL 12×13 -> in_ready=0 for 32 cycles, out_valid rises at cycle 33, alu_result=156. A second op offered meanwhile is not accepted until IDLE.
- out_ready=0 for 5 cycles after an ADD result -> outputs stable and in_ready=0. On release, the next op is accepted the same cycle.
- flush at cycle 10 of a MUL with set_cond=1 -> state IDLE, out_valid=0, cond_out unchanged. rst mid-MUL gives all outputs 0 the next cycle.
